// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: CPU, DMA and DRAM-core signals around the arbiter
interface dram_arbiter_if;
  logic        CPU_CS;
  logic        CPU_AS;
  logic        CPU_RW;
  logic        CPU_LDS;
  logic        CPU_UDS;
  logic [22:0] CPU_ADDR;
  logic        CPU_DTACK;
  logic        DMA_REQ;
  logic        DMA_RW;
  logic [1:0]  DMA_BE;
  logic [22:0] DMA_ADDR;
  logic        DMA_ACK;
  logic        MEM_START;
  logic        MEM_REFRESH;
  logic [22:0] MEM_ADDR;
  logic        MEM_RW;
  logic        MEM_LDS;
  logic        MEM_UDS;
  logic        MEM_DONE;
  logic [1:0]  GRANT;
  modport slave (
    input  CPU_CS, CPU_AS, CPU_RW, CPU_LDS, CPU_UDS, CPU_ADDR,
    input  DMA_REQ, DMA_RW, DMA_BE, DMA_ADDR, MEM_DONE,
    output CPU_DTACK, DMA_ACK, MEM_START, MEM_REFRESH,
    output MEM_ADDR, MEM_RW, MEM_LDS, MEM_UDS, GRANT
  );
  modport master (
    output CPU_CS, CPU_AS, CPU_RW, CPU_LDS, CPU_UDS, CPU_ADDR,
    output DMA_REQ, DMA_RW, DMA_BE, DMA_ADDR, MEM_DONE,
    input  CPU_DTACK, DMA_ACK, MEM_START, MEM_REFRESH,
    input  MEM_ADDR, MEM_RW, MEM_LDS, MEM_UDS, GRANT
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one DRAM core between a 68000 CPU, a DMA master and periodic refresh
module dram_arbiter #(
  parameter int REFRESH_CYCLE_CNT = 150,
  parameter int CNT_W             = 12
) (
  input logic         CLK,
  input logic         RST,
  dram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_HOLD, DMA_ACC, REF_ACC} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             last_dma_q, last_dma_d;
  logic             abort_q, abort_d;
  logic             dtack_q, dtack_d;
  logic             ack_q, ack_d;
  logic             start_q, start_d;
  logic             refresh_q, refresh_d;
  logic [22:0]      addr_q, addr_d;
  logic             rw_q, rw_d;
  logic             lds_q, lds_d;
  logic             uds_q, uds_d;
  logic [1:0]       grant_q, grant_d;
  logic             cpu_req;
  assign cpu_req         = !bus.CPU_CS && !bus.CPU_AS;
  assign bus.CPU_DTACK   = dtack_q;
  assign bus.DMA_ACK     = ack_q;
  assign bus.MEM_START   = start_q;
  assign bus.MEM_REFRESH = refresh_q;
  assign bus.MEM_ADDR    = addr_q;
  assign bus.MEM_RW      = rw_q;
  assign bus.MEM_LDS     = lds_q;
  assign bus.MEM_UDS     = uds_q;
  assign bus.GRANT       = grant_q;
  // next state: refresh timer, fixed-priority/round-robin arbitration and per-owner completion
  always_comb begin
    state_d    = state_q;
    cnt_d      = &cnt_q ? cnt_q : cnt_q + 1'b1;
    pend_d     = pend_q | (cnt_d == CNT_W'(REFRESH_CYCLE_CNT));
    last_dma_d = last_dma_q;
    abort_d    = abort_q;
    dtack_d    = dtack_q;
    ack_d      = 1'b0;
    start_d    = 1'b0;
    refresh_d  = 1'b0;
    addr_d     = addr_q;
    rw_d       = rw_q;
    lds_d      = lds_q;
    uds_d      = uds_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d   = REF_ACC;
          cnt_d     = '0;
          pend_d    = 1'b0;
          refresh_d = 1'b1;
          rw_d      = 1'b1;
          lds_d     = 1'b1;
          uds_d     = 1'b1;
          grant_d   = 2'b11;
        end else if (cpu_req && (!bus.DMA_REQ || last_dma_q)) begin
          state_d    = CPU_ACC;
          start_d    = 1'b1;
          addr_d     = bus.CPU_ADDR;
          rw_d       = bus.CPU_RW;
          lds_d      = bus.CPU_LDS;
          uds_d      = bus.CPU_UDS;
          last_dma_d = 1'b0;
          abort_d    = 1'b0;
          grant_d    = 2'b01;
        end else if (bus.DMA_REQ) begin
          state_d    = DMA_ACC;
          start_d    = 1'b1;
          addr_d     = bus.DMA_ADDR;
          rw_d       = bus.DMA_RW;
          lds_d      = ~bus.DMA_BE[0];
          uds_d      = ~bus.DMA_BE[1];
          last_dma_d = 1'b1;
          grant_d    = 2'b10;
        end
      end
      CPU_ACC: begin
        abort_d = abort_q | bus.CPU_AS;
        if (bus.MEM_DONE) begin
          state_d = abort_d ? IDLE : CPU_HOLD;
          dtack_d = abort_d;
          grant_d = abort_d ? 2'b00 : grant_q;
        end
      end
      CPU_HOLD: begin
        if (bus.CPU_AS) begin
          state_d = IDLE;
          dtack_d = 1'b1;
          grant_d = 2'b00;
        end
      end
      DMA_ACC: begin
        if (bus.MEM_DONE) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          grant_d = 2'b00;
        end
      end
      REF_ACC: begin
        if (bus.MEM_DONE) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset abandons any access in flight without a DTACK or ACK
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      last_dma_q <= 1'b1;
      abort_q    <= 1'b0;
      dtack_q    <= 1'b1;
      ack_q      <= 1'b0;
      start_q    <= 1'b0;
      refresh_q  <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b1;
      lds_q      <= 1'b1;
      uds_q      <= 1'b1;
      grant_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      last_dma_q <= last_dma_d;
      abort_q    <= abort_d;
      dtack_q    <= dtack_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
      refresh_q  <= refresh_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      lds_q      <= lds_d;
      uds_q      <= uds_d;
      grant_q    <= grant_d;
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench with a transaction-level arbiter model
module tb_dram_arbiter;
  localparam int REF = 150;
  localparam int W_DTACK = 0, W_START = 1, W_REF = 2, W_ACK = 3, W_GDMA = 4;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic rsp_done = 1'b0;
  logic spur_done = 1'b0;
  dram_arbiter_if bus();
  dram_arbiter #(.REFRESH_CYCLE_CNT(REF), .CNT_W(12)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  assign bus.MEM_DONE = rsp_done | spur_done;
  always #5 CLK = ~CLK;

  typedef struct { int cyc; int kind; logic [22:0] addr; logic rw; logic lds; logic uds; } cmd_t;
  typedef struct { int cyc; int kind; } rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int owner, since_ref, lat_fix = 3, rcnt;
  bit hold, abort, last_cpu, exp_dtack = 1, prev_dtack = 1, due, got_ref;
  cmd_t c;
  rsp_t r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_cmd(int k, logic [22:0] a, logic rw, logic lds, logic uds);
    cmd_t e;
    e.cyc = cyc; e.kind = k; e.addr = a; e.rw = rw; e.lds = lds; e.uds = uds;
    cmd_q.push_back(e);
  endfunction

  function automatic void push_rsp(int k);
    rsp_t e;
    e.cyc = cyc; e.kind = k;
    rsp_q.push_back(e);
  endfunction

  // reference model: owner 0 none, 1 CPU, 2 DMA, 3 refresh; refresh due 150 edges after reset/last refresh
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner = 0; hold = 0; abort = 0; last_cpu = 0; since_ref = 0; exp_dtack = 1;
      cmd_q.delete(); rsp_q.delete();
    end else begin
      cyc++;
      due = since_ref >= REF;
      got_ref = 0;
      if (owner == 0) begin
        if (due) begin
          owner = 3; got_ref = 1;
          push_cmd(3, 23'h0, 1'b1, 1'b1, 1'b1);
        end else if (!bus.CPU_CS && !bus.CPU_AS && (!bus.DMA_REQ || !last_cpu)) begin
          owner = 1; hold = 0; abort = 0; last_cpu = 1;
          push_cmd(1, bus.CPU_ADDR, bus.CPU_RW, bus.CPU_LDS, bus.CPU_UDS);
        end else if (bus.DMA_REQ) begin
          owner = 2; last_cpu = 0;
          push_cmd(2, bus.DMA_ADDR, bus.DMA_RW, !bus.DMA_BE[0], !bus.DMA_BE[1]);
        end
      end else if (owner == 1 && !hold) begin
        abort = abort | bus.CPU_AS;
        if (bus.MEM_DONE) begin
          if (abort) owner = 0;
          else begin hold = 1; exp_dtack = 0; push_rsp(1); end
        end
      end else if (owner == 1) begin
        if (bus.CPU_AS) begin owner = 0; hold = 0; exp_dtack = 1; end
      end else if (bus.MEM_DONE) begin
        if (owner == 2) push_rsp(2);
        owner = 0;
      end
      since_ref = got_ref ? 0 : since_ref + 1;
    end
  end

  // DRAM core stand-in: MEM_DONE a fixed or random number of cycles after each command
  always @(negedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_done = 0; rcnt = 0;
    end else begin
      rsp_done = 0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) rsp_done = 1;
      end
      if (bus.MEM_START || bus.MEM_REFRESH) rcnt = lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4));
    end
  end

  // monitor: per-cycle owner/DTACK, queued commands and completions
  always @(negedge CLK) begin
    if (!RST) prev_dtack = 1;
    else begin
      chk("grant", bus.GRANT, owner);
      chk("dtack", bus.CPU_DTACK, exp_dtack);
      if (bus.MEM_START || bus.MEM_REFRESH) begin
        if (cmd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cmd: unexpected pulse start=%0b refresh=%0b at cycle %0d", bus.MEM_START, bus.MEM_REFRESH, cyc);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_cycle", cyc, c.cyc);
          chk("cmd_pulse", {bus.MEM_REFRESH, bus.MEM_START}, c.kind == 3 ? 2 : 1);
          if (c.kind != 3) chk("cmd_addr", bus.MEM_ADDR, c.addr);
          chk("cmd_rw", bus.MEM_RW, c.rw);
          chk("cmd_lds", bus.MEM_LDS, c.lds);
          chk("cmd_uds", bus.MEM_UDS, c.uds);
        end
      end
      while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL cmd_missing: no matching pulse, expected kind %0d at cycle %0d", cmd_q[0].kind, cmd_q[0].cyc);
        void'(cmd_q.pop_front());
      end
      if (bus.DMA_ACK || (prev_dtack && !bus.CPU_DTACK)) begin
        if (rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp: unexpected ack=%0b dtack=%0b at cycle %0d", bus.DMA_ACK, bus.CPU_DTACK, cyc);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_cycle", cyc, r.cyc);
          chk("rsp_kind", bus.DMA_ACK ? 2 : 1, r.kind);
        end
      end
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_missing: no matching response, expected kind %0d at cycle %0d", rsp_q[0].kind, rsp_q[0].cyc);
        void'(rsp_q.pop_front());
      end
      prev_dtack = bus.CPU_DTACK;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic bit cond(input int w);
    return w == W_DTACK ? !bus.CPU_DTACK : w == W_START ? bus.MEM_START :
           w == W_REF ? bus.MEM_REFRESH : w == W_ACK ? bus.DMA_ACK : bus.GRANT == 2'b10;
  endfunction

  task automatic wait_until(input int w, input string nm, output int n);
    n = 0;
    do begin @(negedge CLK); n++; end while (!cond(w) && n < 500);
    if (!cond(w)) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: event not seen, got timeout after %0d cycles", nm, n);
    end
  endtask

  task automatic cpu_start(input logic [22:0] a, input logic rw, input logic lds, input logic uds);
    bus.CPU_ADDR = a; bus.CPU_RW = rw; bus.CPU_LDS = lds; bus.CPU_UDS = uds;
    bus.CPU_CS = 0; bus.CPU_AS = 0;
  endtask

  task automatic cpu_end();
    bus.CPU_AS = 1; bus.CPU_CS = 1;
  endtask

  task automatic dma_set(input logic [22:0] a, input logic rw, input logic [1:0] be);
    bus.DMA_ADDR = a; bus.DMA_RW = rw; bus.DMA_BE = be; bus.DMA_REQ = 1;
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_dtack"}, bus.CPU_DTACK, 1);
    chk({p, "_ack"}, bus.DMA_ACK, 0);
    chk({p, "_start"}, bus.MEM_START, 0);
    chk({p, "_refresh"}, bus.MEM_REFRESH, 0);
    chk({p, "_rw"}, bus.MEM_RW, 1);
    chk({p, "_lds"}, bus.MEM_LDS, 1);
    chk({p, "_uds"}, bus.MEM_UDS, 1);
    chk({p, "_addr"}, bus.MEM_ADDR, 0);
    chk({p, "_grant"}, bus.GRANT, 0);
  endtask

  task automatic cpu_rand(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      tick($urandom_range(0, 6));
      cpu_start(23'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 5) == 0) tick($urandom_range(1, 4));
      else begin
        wait_until(W_DTACK, "rnd_dtack", n);
        tick($urandom_range(0, 2));
      end
      cpu_end();
      tick(1);
    end
  endtask

  task automatic dma_rand(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      tick($urandom_range(0, 6));
      dma_set(23'($urandom), 1'($urandom), 2'($urandom));
      n = 0;
      do begin
        @(negedge CLK); n++;
        if (bus.GRANT == 2'b10 && $urandom_range(0, 3) == 0) bus.DMA_REQ = 0;
      end while (!bus.DMA_ACK && n < 500);
      if (!bus.DMA_ACK) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_ack: event not seen, got timeout after %0d cycles", n);
      end
      bus.DMA_REQ = 0;
    end
  endtask

  initial begin
    int n;
    bus.CPU_CS = 1; bus.CPU_AS = 1; bus.CPU_RW = 1; bus.CPU_LDS = 1; bus.CPU_UDS = 1; bus.CPU_ADDR = 0;
    bus.DMA_REQ = 0; bus.DMA_RW = 1; bus.DMA_BE = 0; bus.DMA_ADDR = 0;
    tick(3);
    reset_checks("rst");
    RST = 1;
    tick(2);
    // simultaneous CPU and DMA twice: CPU first, then DMA
    dma_set(23'h7abcd, 0, 2'b01);
    cpu_start(23'h000200, 1, 0, 0);
    wait_until(W_DTACK, "rr_dtack", n);
    chk("rr_grant_cpu", bus.GRANT, 1);
    cpu_end();
    tick(1);
    chk("rr_idle", bus.GRANT, 0);
    cpu_start(23'h000300, 1, 0, 1);
    tick(1);
    chk("rr_grant_dma", bus.GRANT, 2);
    chk("rr_dma_lds", bus.MEM_LDS, 0);
    chk("rr_dma_uds", bus.MEM_UDS, 1);
    wait_until(W_ACK, "rr_ack", n);
    bus.DMA_REQ = 0;
    wait_until(W_DTACK, "rr_dtack2", n);
    cpu_end();
    tick(2);
    // CPU read at 0x000100, core answers 3 cycles after MEM_START
    cpu_start(23'h000100, 1, 0, 0);
    wait_until(W_START, "rd_start", n);
    wait_until(W_DTACK, "rd_dtack", n);
    chk("rd_dtack_lat", n, 4);
    chk("rd_addr", bus.MEM_ADDR, 23'h000100);
    cpu_end();
    tick(1);
    chk("rd_dtack_rel", bus.CPU_DTACK, 1);
    // MEM_DONE while idle is ignored
    tick(2);
    spur_done = 1;
    tick(1);
    spur_done = 0;
    tick(1);
    chk("spur_grant", bus.GRANT, 0);
    chk("spur_ack", bus.DMA_ACK, 0);
    // refresh after idling; CPU arriving during refresh waits for DONE plus one idle cycle
    wait_until(W_REF, "ref_pulse", n);
    chk("ref_grant", bus.GRANT, 3);
    cpu_start(23'h000400, 0, 1, 0);
    wait_until(W_START, "ref_cpu_start", n);
    chk("ref_cpu_wait", n, 5);
    chk("ref_cpu_grant", bus.GRANT, 1);
    wait_until(W_DTACK, "ref_cpu_dtack", n);
    cpu_end();
    tick(1);
    // aborted CPU cycle: no DTACK, DMA served next
    lat_fix = 4;
    cpu_start(23'h000500, 1, 0, 0);
    wait_until(W_START, "ab_start", n);
    tick(1);
    cpu_end();
    dma_set(23'h012345, 1, 2'b11);
    wait_until(W_START, "ab_dma_start", n);
    chk("ab_dma_lat", n, 5);
    chk("ab_dma_grant", bus.GRANT, 2);
    chk("ab_no_dtack", bus.CPU_DTACK, 1);
    wait_until(W_ACK, "ab_ack", n);
    bus.DMA_REQ = 0;
    tick(2);
    // reset in the middle of a DMA access
    lat_fix = 6;
    dma_set(23'h055aa5, 0, 2'b10);
    wait_until(W_GDMA, "arst_grant", n);
    #2 RST = 0;
    #1 reset_checks("arst");
    bus.DMA_REQ = 0;
    tick(2);
    RST = 1;
    wait_until(W_REF, "arst_ref", n);
    chk("arst_ref_lat", n, REF + 1);
    tick(1);
    // randomized contention
    lat_fix = 0;
    fork
      cpu_rand(40);
      dma_rand(40);
    join
    tick(20);
    chk("drain_cmd", cmd_q.size(), 0);
    chk("drain_rsp", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
